data_sram_responder: RTL and testbench

//  Target side of the CPU data SRAM port (en/we/addr/wdata -> rdata). Serves loads/stores with fixed 1-cycle read latency.

---
 rtl/data_sram_pkg.sv | 43 ++++
 rtl/data_sram_responder_if.sv | 24 ++
 rtl/data_sram_responder_conf_regs.sv | 75 +++++++
 rtl/data_sram_responder.sv | 68 ++++++
 tb/tb_data_sram_responder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/data_sram_pkg.sv
// Shared definitions for the data SRAM responder: config-window offsets, register selects,
// and the byte-lane merge used by every writable target.
package data_sram_pkg;

  localparam logic [15:0] CONF_BASE_DEF = 16'hBFAF;

  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_NUM    = 16'hF010;
  localparam logic [15:0] OFF_SWITCH = 16'hF020;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;

  typedef enum logic [2:0] {
    SelNone,
    SelLed,
    SelNum,
    SelSwitch,
    SelTimer
  } conf_sel_e;

  function automatic conf_sel_e decode_conf(input logic [15:0] offset);
    conf_sel_e sel;
    case (offset)
      OFF_LED:    sel = SelLed;
      OFF_NUM:    sel = SelNum;
      OFF_SWITCH: sel = SelSwitch;
      OFF_TIMER:  sel = SelTimer;
      default:    sel = SelNone;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  we);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU data SRAM port: the CPU drives request fields, the responder returns read data.
interface data_sram_responder_if;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (
    output sram_en,
    output sram_we,
    output sram_addr,
    output sram_wdata,
    input  sram_rdata
  );

  modport slave (
    input  sram_en,
    input  sram_we,
    input  sram_addr,
    input  sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/data_sram_responder_conf_regs.sv
// Config-register window: LED, NUM, free-running TIMER, synchronised SWITCH input and the
// combinational read mux the top registers into sram_rdata.
module data_sram_responder_conf_regs
  import data_sram_pkg::*;
#(
  parameter logic [31:0] TIMER_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        acc,
  input  logic [3:0]  we,
  input  logic [15:0] offset,
  input  logic [31:0] wdata,
  input  logic [7:0]  switch_in,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic [31:0] num
);

  conf_sel_e   sel;
  logic        wr;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  sw_meta_q, sw_sync_q;

  assign sel = decode_conf(offset);
  assign wr  = acc && (we != 4'b0000);

  always_comb begin
    led_d   = led_q;
    num_d   = num_q;
    timer_d = timer_q + 32'd1;
    if (wr) begin
      unique case (sel)
        SelLed:   led_d = {we[1] ? wdata[15:8] : led_q[15:8], we[0] ? wdata[7:0] : led_q[7:0]};
        SelNum:   num_d = merge_be(num_q, wdata, we);
        // A timer write replaces this cycle's increment.
        SelTimer: timer_d = merge_be(timer_q, wdata, we);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= 16'h0;
      num_q     <= 32'h0;
      timer_q   <= TIMER_RST;
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
    end else begin
      led_q     <= led_d;
      num_q     <= num_d;
      timer_q   <= timer_d;
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  always_comb begin
    rdata = 32'h0;
    unique case (sel)
      SelLed:    rdata = {16'h0, led_q};
      SelNum:    rdata = num_q;
      SelSwitch: rdata = {24'h0, sw_sync_q};
      SelTimer:  rdata = timer_q;
      default:   rdata = 32'h0;
    endcase
  end

  assign led = led_q;
  assign num = num_q;

endmodule

// File: rtl/data_sram_responder.sv
// Target side of the CPU data SRAM port: word RAM plus config window, 1-cycle read latency,
// read-first on writes.
module data_sram_responder
  import data_sram_pkg::*;
#(
  parameter int unsigned RAM_AW    = 16,
  parameter logic [15:0] CONF_BASE = CONF_BASE_DEF,
  parameter logic [31:0] TIMER_RST = 32'h0
) (
  input  logic                        clk,
  input  logic                        reset,
  data_sram_responder_if.slave        bus,
  input  logic [7:0]                  switch_in,
  output logic [15:0]                 led_out,
  output logic [31:0]                 num_out
);

  localparam int unsigned Depth = 1 << RAM_AW;

  logic [31:0]       ram [Depth];
  logic [RAM_AW-1:0] ram_idx;
  logic              is_conf;
  logic              req;
  logic [31:0]       conf_rdata;
  logic [31:0]       rdata_q;
  logic              unused_addr;

  // Upper RAM address bits beyond RAM_AW are ignored, so the RAM aliases through the space.
  assign ram_idx     = bus.sram_addr[RAM_AW+1:2];
  assign is_conf     = (bus.sram_addr[31:16] == CONF_BASE);
  assign req         = bus.sram_en && !reset;
  assign unused_addr = ^bus.sram_addr[1:0];

  data_sram_responder_conf_regs #(
    .TIMER_RST (TIMER_RST)
  ) u_conf_regs (
    .clk       (clk),
    .reset     (reset),
    .acc       (req && is_conf),
    .we        (bus.sram_we),
    .offset    (bus.sram_addr[15:0]),
    .wdata     (bus.sram_wdata),
    .switch_in (switch_in),
    .rdata     (conf_rdata),
    .led       (led_out),
    .num       (num_out)
  );

  // Content is not reset; byte lanes written independently.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req && !is_conf && bus.sram_we[i]) begin
        ram[ram_idx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'h0;
    end else if (req) begin
      rdata_q <= is_conf ? conf_rdata : ram[ram_idx];
    end
  end

  assign bus.sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench: directed vector table, hand sequences for timer/reset, then random
// traffic against a behavioural model of the port.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  switch_in;
  logic [15:0] led_out;
  logic [31:0] num_out;

  data_sram_responder_if bus();

  data_sram_responder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .switch_in (switch_in),
    .led_out   (led_out),
    .num_out   (num_out)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state.
  logic [31:0] m_mem [int];
  logic [31:0] m_rdata;
  bit          m_rd_known;
  logic [15:0] m_led;
  logic [31:0] m_num;
  logic [31:0] m_timer;
  logic [7:0]  m_sw [2];
  bit          model_chk = 1'b0;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic model_step(input bit r, input bit e, input logic [3:0] w,
                            input logic [31:0] a, input logic [31:0] d);
    logic [31:0] t0;
    logic [31:0] tmp;
    logic [7:0]  sw_seen;
    bit          t_wr;
    int          idx;
    if (r) begin
      m_rdata = 0; m_rd_known = 1; m_led = 0; m_num = 0; m_timer = 32'h0;
      m_sw[0] = 0; m_sw[1] = 0;
      return;
    end
    t0      = m_timer;
    t_wr    = 0;
    sw_seen = m_sw[1];
    m_sw[1] = m_sw[0];
    m_sw[0] = switch_in;
    if (e) begin
      if (a[31:16] == 16'hBFAF) begin
        m_rd_known = 1;
        case (a[15:0])
          16'hF000: begin
            m_rdata = {16'h0, m_led};
            if (w != 0) begin tmp = bmerge({16'h0, m_led}, d, w); m_led = tmp[15:0]; end
          end
          16'hF010: begin m_rdata = m_num; if (w != 0) m_num = bmerge(m_num, d, w); end
          16'hF020: m_rdata = {24'h0, sw_seen};
          16'hE000: begin
            m_rdata = t0;
            if (w != 0) begin m_timer = bmerge(t0, d, w); t_wr = 1; end
          end
          default:  m_rdata = 0;
        endcase
      end else begin
        idx = int'(a[17:2]);
        if (m_mem.exists(idx)) begin m_rdata = m_mem[idx]; m_rd_known = 1; end
        else m_rd_known = 0;
        if (w != 0) begin
          if (m_mem.exists(idx)) m_mem[idx] = bmerge(m_mem[idx], d, w);
          else if (w == 4'hF) m_mem[idx] = d;
        end
      end
    end
    if (!t_wr) m_timer = t0 + 32'd1;
  endtask

  task automatic cycle(input bit r, input bit e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    reset          = r;
    bus.sram_en    = e;
    bus.sram_we    = w;
    bus.sram_addr  = a;
    bus.sram_wdata = d;
    @(posedge clk);
    model_step(r, e, w, a, d);
    #1;
    if (model_chk) begin
      if (m_rd_known) chk("model_rdata", bus.sram_rdata, m_rdata);
      chk("model_led", {16'h0, led_out}, {16'h0, m_led});
      chk("model_num", num_out, m_num);
    end
  endtask

  typedef struct {
    bit          en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
    logic [31:0] exp_num;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit en, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit chk_rd, input logic [31:0] exp_rd,
                     input logic [15:0] exp_led, input logic [31:0] exp_num);
    vec_t v;
    v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_led = exp_led; v.exp_num = exp_num;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] t1, t2;
    logic [31:0] offs [5];
    logic [31:0] a;
    logic [3:0]  w;
    reset = 1'b1; bus.sram_en = 0; bus.sram_we = 0; bus.sram_addr = 0; bus.sram_wdata = 0;
    switch_in = 8'h3C;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("reset_rdata", bus.sram_rdata, 32'h0);
    chk("reset_led", {16'h0, led_out}, 32'h0);
    chk("reset_num", num_out, 32'h0);

    //  en we     addr          wdata         chk exp_rd        led      num
    add(1, 4'hF, 32'h0000_0010, 32'h1234_5678, 0, 32'h0,        16'h0,    32'h0);
    add(1, 4'h0, 32'h0000_0010, 32'h0,         1, 32'h1234_5678, 16'h0,   32'h0);
    add(1, 4'hF, 32'h0000_0020, 32'hAABB_CCDD, 0, 32'h0,        16'h0,    32'h0);
    add(1, 4'h5, 32'h0000_0020, 32'h1122_3344, 1, 32'hAABB_CCDD, 16'h0,   32'h0);
    add(1, 4'h0, 32'h0000_0020, 32'h0,         1, 32'hAA22_CC44, 16'h0,   32'h0);
    add(1, 4'h0, 32'hBFAF_1234, 32'h0,         1, 32'h0,        16'h0,    32'h0);
    add(1, 4'hF, 32'h0004_0004, 32'hCAFE_F00D, 0, 32'h0,        16'h0,    32'h0);
    add(1, 4'h0, 32'h0000_0004, 32'h0,         1, 32'hCAFE_F00D, 16'h0,   32'h0);
    add(1, 4'hF, 32'hBFAF_F000, 32'h0000_A5A5, 1, 32'h0,        16'hA5A5, 32'h0);
    add(1, 4'h0, 32'hBFAF_F000, 32'h0,         1, 32'h0000_A5A5, 16'hA5A5, 32'h0);
    add(0, 4'h0, 32'h0000_0020, 32'h0,         1, 32'h0000_A5A5, 16'hA5A5, 32'h0);
    add(1, 4'hF, 32'hBFAF_F010, 32'hDEAD_BEEF, 1, 32'h0,        16'hA5A5, 32'hDEAD_BEEF);
    add(1, 4'hF, 32'hBFAF_F020, 32'hFFFF_FFFF, 1, 32'h0000_003C, 16'hA5A5, 32'hDEAD_BEEF);
    add(1, 4'h0, 32'hBFAF_F020, 32'h0,         1, 32'h0000_003C, 16'hA5A5, 32'hDEAD_BEEF);
    add(1, 4'h3, 32'hBFAF_F000, 32'hFFFF_1234, 1, 32'h0000_A5A5, 16'h1234, 32'hDEAD_BEEF);
    add(1, 4'h0, 32'hBFAF_F000, 32'h0,         1, 32'h0000_1234, 16'h1234, 32'hDEAD_BEEF);

    foreach (tbl[i]) begin
      cycle(0, tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), bus.sram_rdata, tbl[i].exp_rd);
      chk($sformatf("vec%0d_led", i), {16'h0, led_out}, {16'h0, tbl[i].exp_led});
      chk($sformatf("vec%0d_num", i), num_out, tbl[i].exp_num);
    end

    // Timer: consecutive reads step by one, then wrap after a near-max write.
    cycle(0, 1, 0, 32'hBFAF_E000, 0); t1 = bus.sram_rdata;
    cycle(0, 1, 0, 32'hBFAF_E000, 0); t2 = bus.sram_rdata;
    chk("timer_step", t2 - t1, 32'd1);
    cycle(0, 1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 32'hBFAF_E000, 0);
    chk("timer_wrap", bus.sram_rdata, 32'h0);

    // Reset with a read pending and a write attempted; RAM must survive.
    cycle(0, 1, 0, 32'h0000_0010, 0);
    chk("pre_reset_rd", bus.sram_rdata, 32'h1234_5678);
    cycle(1, 1, 0, 32'h0000_0010, 0);
    chk("rst_drop_rdata", bus.sram_rdata, 32'h0);
    chk("rst_led", {16'h0, led_out}, 32'h0);
    chk("rst_num", num_out, 32'h0);
    cycle(1, 1, 4'hF, 32'h0000_0010, 32'hBAD0_BAD0);
    cycle(0, 1, 0, 32'hBFAF_E000, 0);
    chk("rst_timer", bus.sram_rdata, 32'h0);
    cycle(0, 1, 0, 32'h0000_0010, 0);
    chk("ram_survives_reset", bus.sram_rdata, 32'h1234_5678);

    // Random traffic against the model.
    model_chk = 1'b1;
    for (int i = 0; i < 16; i++) cycle(0, 1, 4'hF, 32'h100 + 32'(4 * i), $urandom);
    offs[0] = 32'hF000; offs[1] = 32'hF010; offs[2] = 32'hF020;
    offs[3] = 32'hE000; offs[4] = 32'h1234;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) switch_in = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        a = {16'hBFAF, offs[$urandom_range(0, 4)][15:0]};
      end else begin
        a = 32'h100 + 32'(4 * $urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) a = a + 32'h0004_0000;
      end
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      cycle(0, ($urandom_range(0, 4) != 0), w, a, $urandom);
    end
    model_chk = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
